gpio_reg_arbiter: RTL and testbench
===================================

GPIO_REG_ARBITER -- requirements
Module: gpio_reg_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the GPIO register data path.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports m0_valid, m1_valid  input  1  request present (m0 = CPU decoder path, m1 = debug/UART bridge).
REQ-005 SHALL have ports m0_wen, m1_wen  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports m0_wdata, m1_wdata  input  DATA_W  write data.
REQ-007 SHALL have ports m0_ready, m1_ready  output  1  request accepted (one-cycle pulse).
REQ-008 SHALL have ports m0_rvalid, m1_rvalid  output  1  completion pulse.
REQ-009 SHALL have ports m0_rdata, m1_rdata  output  DATA_W  read result, valid with rvalid.
REQ-010 SHALL have ports io_reg_valid, io_reg_wen, io_reg_ren  output  1  GPIO register port strobes.
REQ-011 SHALL have port io_reg_wdata  output  DATA_W  GPIO register write data.
REQ-012 SHALL have port io_reg_rdata  input  DATA_W  GPIO register read data, valid in the cycle io_reg_valid & io_reg_ren.
REQ-013 SHALL have port busy  output  1  state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, RESP; every transaction takes exactly 3 cycles: IDLE (accept) -> ISSUE -> RESP -> IDLE.
REQ-015 IDLE: if any mX_valid, SHALL select one requester, assert its mX_ready for that cycle, latch its wen/wdata and grant id, and go to ISSUE; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with only one valid, grant it; with both valid, grant the requester not granted last; last_grant updates only on accept.
REQ-017 ISSUE: SHALL drive io_reg_valid=1 for exactly one cycle, io_reg_wen=latched wen, io_reg_ren=~latched wen, io_reg_wdata=latched wdata; for reads, capture io_reg_rdata at the end of this cycle.
REQ-018 Outside ISSUE, io_reg_valid, io_reg_wen and io_reg_ren SHALL be 0 and io_reg_wdata SHALL be 0.
REQ-019 RESP: SHALL assert rvalid of the granted requester only, for one cycle; rdata = captured value for reads, 0 for writes; then return to IDLE.
REQ-020 mX_rdata SHALL be 0 whenever mX_rvalid is 0.
REQ-021 mX_ready SHALL never be asserted outside IDLE; requests arriving in ISSUE/RESP SHALL wait, and requesters SHALL hold valid/wen/wdata until ready.
REQ-022 A requester deasserting valid before ready SHALL produce no transaction and no change to last_grant.
REQ-023 A requester may re-request in the IDLE cycle following its own RESP; round-robin SHALL then grant the other requester if it is also valid.
REQ-024 At most one mX_ready and at most one mX_rvalid SHALL be high in any cycle.

Reset
REQ-025 While reset=0: state=IDLE, last_grant=m1 (so m0 wins the first contention), latched data/capture registers=0, all outputs 0.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately: no io_reg_valid and no rvalid after reset deassertion for that transaction.
REQ-027 After reset deassertion, the first accept SHALL occur at the first rising edge with any mX_valid=1.

Verification
REQ-028 m0 write 0x12345678 alone -> m0_ready at cycle 0; cycle 1 io_reg_valid=1, io_reg_wen=1, io_reg_wdata=0x12345678; cycle 2 m0_rvalid=1, m0_rdata=0.
REQ-029 m1 read, io_reg_rdata=0x55AA33CC -> cycle 1 io_reg_ren=1; cycle 2 m1_rvalid=1, m1_rdata=0x55AA33CC; m0 outputs stay 0.
REQ-030 First contention after reset, both valid (m0 wdata 0xAABBCCDD, m1 wdata 0xDEADBEEF), held -> m0 accepted first, m1 accepted in the IDLE cycle 3 cycles later; io_reg_wdata shows 0xAABBCCDD then 0xDEADBEEF.
REQ-031 Both requesters hold valid continuously for 12 cycles -> grants alternate m0,m1,m0,m1; exactly 4 io_reg_valid pulses; busy low only in accept cycles.
REQ-032 reset=0 applied during ISSUE of an m0 read -> all outputs 0 at once; after release with no requests, no rvalid and busy=0.
REQ-033 m1_valid raised in RESP of an m0 transaction -> m1_ready not asserted until the next IDLE cycle; m1 transaction completes normally.

Source files
------------

// File: rtl/gpio_reg_arbiter.sv
// Two-master round-robin arbiter in front of a single GPIO register port.
// Each transaction runs IDLE (accept) -> ISSUE -> RESP -> IDLE.
module gpio_reg_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              io_reg_valid,
  output logic              io_reg_wen,
  output logic              io_reg_ren,
  output logic [DATA_W-1:0] io_reg_wdata,
  input  logic [DATA_W-1:0] io_reg_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant;
  logic                r_gnt;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_pick;
  logic                w_accept;

  // Contention goes to whoever did not win last; otherwise the lone requester.
  assign w_pick   = (m0_valid && m1_valid) ? ~r_last_grant : m1_valid;
  assign w_accept = (r_state == IDLE) && (m0_valid || m1_valid);
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt        <= w_pick;
        r_last_grant <= w_pick;
        r_wen        <= w_pick ? m1_wen   : m0_wen;
        r_wdata      <= w_pick ? m1_wdata : m0_wdata;
      end
      if (r_state == ISSUE && !r_wen) begin
        r_rdata <= io_reg_rdata;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    io_reg_valid = 1'b0;
    io_reg_wen   = 1'b0;
    io_reg_ren   = 1'b0;
    io_reg_wdata = '0;
    case (r_state)
      IDLE: begin
        // Gated by reset so ready stays low while reset is held.
        if (reset && w_accept) begin
          w_next = ISSUE;
          if (w_pick) m1_ready = 1'b1;
          else        m0_ready = 1'b1;
        end
      end
      ISSUE: begin
        w_next       = RESP;
        io_reg_valid = 1'b1;
        io_reg_wen   = r_wen;
        io_reg_ren   = ~r_wen;
        io_reg_wdata = r_wdata;
      end
      RESP: begin
        w_next = IDLE;
        if (r_gnt) begin
          m1_rvalid = 1'b1;
          m1_rdata  = r_wen ? '0 : r_rdata;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = r_wen ? '0 : r_rdata;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Directed bench for gpio_reg_arbiter: single-requester vector table plus
// hand-written contention, back-to-back, late-arrival and reset-abort sequences.
module tb_gpio_reg_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_valid, m0_wen, m1_valid, m1_wen;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        io_reg_valid, io_reg_wen, io_reg_ren;
  logic [31:0] io_reg_wdata, io_reg_rdata;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  gpio_reg_arbiter #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .io_reg_valid(io_reg_valid), .io_reg_wen(io_reg_wen), .io_reg_ren(io_reg_ren),
    .io_reg_wdata(io_reg_wdata), .io_reg_rdata(io_reg_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        m;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rd_in;
    logic        exp_wen;
    logic        exp_ren;
    logic [31:0] exp_io_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ready"},  {30'd0, m1_ready, m0_ready}, 32'd0);
    chk({nm, " rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk({nm, " rdata0"}, m0_rdata, 32'd0);
    chk({nm, " rdata1"}, m1_rdata, 32'd0);
    chk({nm, " io_strb"}, {29'd0, io_reg_valid, io_reg_wen, io_reg_ren}, 32'd0);
    chk({nm, " io_wdata"}, io_reg_wdata, 32'd0);
    chk({nm, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  logic [3:0] grants;
  int         n_acc, n_pulse, n_idle, n_both;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h12345678, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'h13572468, 32'h55AA33CC, 1'b0, 1'b1, 32'h13572468, 32'h55AA33CC};
    vecs[2] = '{1'b0, 1'b0, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 32'h00000001};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000};
    vecs[4] = '{1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF};

    reset = 1'b0;
    m0_valid = 1'b1; m0_wen = 1'b1; m0_wdata = 32'h11111111;
    m1_valid = 1'b1; m1_wen = 1'b0; m1_wdata = 32'h22222222;
    io_reg_rdata = 32'h0;
    repeat (2) @(posedge clock);
    samp();
    chk_all_zero("reset_hold");
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();
    reset = 1'b1;
    step();

    // First contention after reset: m0 wins, m1 follows 3 cycles later.
    m0_valid = 1'b1; m0_wen = 1'b1; m0_wdata = 32'hAABBCCDD;
    m1_valid = 1'b1; m1_wen = 1'b1; m1_wdata = 32'hDEADBEEF;
    samp();
    chk("cont m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("cont m1_ready0", {31'd0, m1_ready}, 32'd0);
    step(); m0_valid = 1'b0;
    samp();
    chk("cont io_wdata0", io_reg_wdata, 32'hAABBCCDD);
    chk("cont m1_wait_issue", {31'd0, m1_ready}, 32'd0);
    step(); samp();
    chk("cont m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("cont m1_wait_resp", {31'd0, m1_ready}, 32'd0);
    step(); samp();
    chk("cont m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("cont busy_idle", {31'd0, busy}, 32'd0);
    step(); m1_valid = 1'b0;
    samp();
    chk("cont io_wdata1", io_reg_wdata, 32'hDEADBEEF);
    step(); samp();
    chk("cont m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("cont m1_rdata", m1_rdata, 32'd0);
    step();

    // Single-requester transactions from the table.
    for (int i = 0; i < 5; i++) begin
      io_reg_rdata = vecs[i].rd_in;
      if (vecs[i].m) begin
        m1_valid = 1'b1; m1_wen = vecs[i].wen; m1_wdata = vecs[i].wdata;
      end else begin
        m0_valid = 1'b1; m0_wen = vecs[i].wen; m0_wdata = vecs[i].wdata;
      end
      samp();
      chk($sformatf("v%0d ready", i), {30'd0, m1_ready, m0_ready}, vecs[i].m ? 32'd2 : 32'd1);
      chk($sformatf("v%0d busy_acc", i), {31'd0, busy}, 32'd0);
      step(); m0_valid = 1'b0; m1_valid = 1'b0;
      samp();
      chk($sformatf("v%0d io_valid", i), {31'd0, io_reg_valid}, 32'd1);
      chk($sformatf("v%0d io_wen_ren", i), {30'd0, io_reg_wen, io_reg_ren},
          {30'd0, vecs[i].exp_wen, vecs[i].exp_ren});
      chk($sformatf("v%0d io_wdata", i), io_reg_wdata, vecs[i].exp_io_wdata);
      chk($sformatf("v%0d ready_issue", i), {30'd0, m1_ready, m0_ready}, 32'd0);
      step();
      io_reg_rdata = 32'h0BAD0BAD;
      samp();
      chk($sformatf("v%0d rvalid", i), {30'd0, m1_rvalid, m0_rvalid}, vecs[i].m ? 32'd2 : 32'd1);
      chk($sformatf("v%0d rdata", i), vecs[i].m ? m1_rdata : m0_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d other_rdata", i), vecs[i].m ? m0_rdata : m1_rdata, 32'd0);
      chk($sformatf("v%0d io_idle", i), {29'd0, io_reg_valid, io_reg_wen, io_reg_ren}, 32'd0);
      chk($sformatf("v%0d io_wdata_idle", i), io_reg_wdata, 32'd0);
      step(); samp();
      chk($sformatf("v%0d busy_end", i), {31'd0, busy}, 32'd0);
      step();
    end

    // Both held for 12 cycles: last grant was m1, so m0,m1,m0,m1.
    m0_valid = 1'b1; m0_wen = 1'b0; m0_wdata = 32'h0;
    m1_valid = 1'b1; m1_wen = 1'b0; m1_wdata = 32'h0;
    grants = 4'd0; n_acc = 0; n_pulse = 0; n_idle = 0; n_both = 0;
    for (int c = 0; c < 12; c++) begin
      samp();
      if (m0_ready && m1_ready) n_both++;
      if ((m0_ready || m1_ready) && n_acc < 4) begin
        grants[n_acc] = m1_ready;
        n_acc++;
      end
      if (io_reg_valid) n_pulse++;
      if (!busy) n_idle++;
      if (m0_rvalid && m1_rvalid) n_both++;
      @(posedge clock);
    end
    #1; m0_valid = 1'b0; m1_valid = 1'b0;
    chk("rr accepts", n_acc, 32'd4);
    chk("rr order", {28'd0, grants}, 32'b1010);
    chk("rr io_pulses", n_pulse, 32'd4);
    chk("rr busy_low", n_idle, 32'd4);
    chk("rr exclusive", n_both, 32'd0);

    // m1 arrives during RESP of an m0 transaction.
    io_reg_rdata = 32'h00C0FFEE;
    m0_valid = 1'b1; m0_wen = 1'b0;
    samp();
    chk("late m0_ready", {31'd0, m0_ready}, 32'd1);
    step(); m0_valid = 1'b0;
    step();
    m1_valid = 1'b1; m1_wen = 1'b1; m1_wdata = 32'h0BADF00D;
    samp();
    chk("late m1_wait", {31'd0, m1_ready}, 32'd0);
    chk("late m0_rdata", m0_rdata, 32'h00C0FFEE);
    step(); samp();
    chk("late m1_ready", {31'd0, m1_ready}, 32'd1);
    step(); m1_valid = 1'b0;
    samp();
    chk("late io_wdata", io_reg_wdata, 32'h0BADF00D);
    step(); samp();
    chk("late m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    step();

    // Reset during ISSUE of an m0 read aborts it.
    m0_valid = 1'b1; m0_wen = 1'b0;
    step(); m0_valid = 1'b0;
    samp();
    chk("abort io_valid_pre", {31'd0, io_reg_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("abort_now");
    step();
    reset = 1'b1;
    n_pulse = 0;
    for (int c = 0; c < 4; c++) begin
      samp();
      if (m0_rvalid || m1_rvalid || io_reg_valid || busy) n_pulse++;
    end
    chk("abort quiet", n_pulse, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
